bram_stream_reader: RTL and testbench

- Initiator for a single BRAM port (en/we/addr/din/dout/ready style, 1-cycle read latency, ready = registered en).
- On a start command, reads `len` consecutive words from `base_addr`, wrapping at DEPTH, and presents them as a valid/ready stream with a last flag.
- A 4-entry output FIFO plus credit counting absorbs read latency and back-pressure, so no read data is ever dropped.
- Sits between frame/line buffers and downstream consumers.

---
 rtl/bram_stream_reader.sv | 128 ++++++++++++
 tb/tb_bram_stream_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Reads len consecutive words from a 1-cycle-latency BRAM port, starting at base_addr and wrapping at DEPTH.
// The words leave as a valid/ready stream with a last flag. Credits on a 4-entry FIFO make sure no returned word is dropped.
module bram_stream_reader #(
  parameter  int WIDTH      = 8,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_rready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] next_addr_reg, last_addr_reg, addr_inc;
  logic [LEN_WIDTH-1:0]  to_issue_reg, to_accept_reg, to_return_reg;
  logic [1:0]            inflight_reg;
  logic [WIDTH:0]        fifo_mem [4];
  logic [1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [2:0]            count_reg;
  logic [3:0]            credit_used;
  logic                  accept_start, issue, push, pop, push_last;

  assign accept_start = (state_reg == IDLE) && start;
  assign credit_used  = 4'(count_reg) + 4'(inflight_reg);
  assign issue        = (state_reg == RUN) && (to_issue_reg != '0) && (credit_used < 4'd4);
  // Returns arriving in IDLE belong to a command abandoned by reset.
  assign push         = mem_rready && (state_reg != IDLE);
  assign push_last    = (to_return_reg == LEN_WIDTH'(1));
  assign m_valid      = (count_reg != '0);
  assign pop          = m_valid && m_ready;
  assign addr_inc     = (next_addr_reg == ADDR_WIDTH'(DEPTH - 1)) ? '0 : next_addr_reg + 1'b1;

  assign m_data    = fifo_mem[rd_ptr_reg][WIDTH-1:0];
  assign m_last    = m_valid && fifo_mem[rd_ptr_reg][WIDTH];
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? FIN : RUN;
      RUN:     if (issue && (to_issue_reg == LEN_WIDTH'(1))) state_next = DRAIN;
      DRAIN:   if (pop && (to_accept_reg == LEN_WIDTH'(1))) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    done     = (state_reg == FIN);
    mem_en   = issue;
    mem_addr = issue ? next_addr_reg : last_addr_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_addr_reg <= '0;
      last_addr_reg <= '0;
      to_issue_reg  <= '0;
      to_accept_reg <= '0;
      to_return_reg <= '0;
      inflight_reg  <= '0;
    end else if (accept_start) begin
      next_addr_reg <= base_addr;
      to_issue_reg  <= len;
      to_accept_reg <= len;
      to_return_reg <= len;
    end else begin
      if (issue) begin
        next_addr_reg <= addr_inc;
        last_addr_reg <= next_addr_reg;
        to_issue_reg  <= to_issue_reg - 1'b1;
      end
      if (pop)  to_accept_reg <= to_accept_reg - 1'b1;
      if (push) to_return_reg <= to_return_reg - 1'b1;
      case ({issue, push})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // Tag bit above the data marks the len-th returned word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_reg] <= {push_last, mem_rdata};
        wr_ptr_reg           <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Random and directed checks of bram_stream_reader against a queue-style model of the expected word stream.
// The attached BRAM has a 1-cycle read latency and DEPTH=16.
module tb_bram_stream_reader;

  localparam int W = 8;
  localparam int D = 16;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, m_ready;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, m_valid, m_last, mem_en, mem_we;
  logic [W-1:0]  m_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic          mem_rready = 1'b0;

  logic [W-1:0]  bmem [D];
  int vectors = 0;
  int miscompares = 0;

  bram_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rready(mem_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rready <= mem_en;
    if (mem_en) mem_rdata <= bmem[mem_addr];
  end

  // Monitor: logs activity per cycle; cycle 1 is the first cycle after the start edge.
  logic         clr;
  int           cyc, issued, popped, obs_n, addr_n, done_cnt, done_cyc, first_valid;
  int           valid_cnt, busy_cnt, stall_err, credit_err, last_issue;
  logic [W-1:0] obs_data [64];
  logic         obs_last [64];
  int           hs_cyc [64];
  logic [AW-1:0] addr_log [64];
  logic         prev_stall;
  logic [W-1:0] prev_data;

  always @(negedge clk) begin
    if (clr) begin
      cyc <= 1; issued <= 0; popped <= 0; obs_n <= 0; addr_n <= 0; done_cnt <= 0;
      done_cyc <= -1; first_valid <= -1; valid_cnt <= 0; busy_cnt <= 0;
      stall_err <= 0; credit_err <= 0; last_issue <= -1; prev_stall <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (mem_en) begin
        issued <= issued + 1;
        last_issue <= cyc;
        if (addr_n < 64) addr_log[addr_n] <= mem_addr;
        addr_n <= addr_n + 1;
      end
      if (m_valid) begin
        valid_cnt <= valid_cnt + 1;
        if (first_valid < 0) first_valid <= cyc;
      end
      if (m_valid && m_ready) begin
        if (obs_n < 64) begin
          obs_data[obs_n] <= m_data;
          obs_last[obs_n] <= m_last;
          hs_cyc[obs_n]   <= cyc;
        end
        obs_n  <= obs_n + 1;
        popped <= popped + 1;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err <= stall_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      // Words issued but not yet consumed = FIFO occupancy + reads in flight.
      if (issued - popped > 4) credit_err <= credit_err + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  function automatic logic rdy(input int mode, input int k);
    int p;
    p = (k - 1) % 6;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (p == 0 || p == 3 || p == 5);
    return ($urandom_range(3) != 0);
  endfunction

  task automatic run_cmd(input int base, input int n, input int mode, input int inject, output bit to);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); len = LW'(n); clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0; m_ready = rdy(mode, 1);
    to = 1'b1;
    for (int k = 2; k < 300; k++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin to = 1'b0; break; end
      m_ready = rdy(mode, k);
      if (inject != 0 && k == inject) begin
        start = 1'b1; base_addr = 4'd9; len = 5'd3;
      end else start = 1'b0;
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("cmd base=%0d len=%0d mode=%0d words=%0d issued=%0d done=%0d", base, n, mode, obs_n, issued, done_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0; clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; clr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, m_valid, m_last, m_data, mem_en, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b valid=%b last=%b data=%h en=%b addr=%h want all 0",
               busy, done, m_valid, m_last, m_data, mem_en, mem_addr);
    end
    $display("reset applied");
  endtask

  task automatic test_basic();
    bit to;
    run_cmd(10, 4, 0, 0, to);
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got no done want done"); end
    vectors++; if (obs_n !== 4) begin miscompares++; $display("FAIL basic_count got %0d want 4", obs_n); end
    for (int k = 0; k < 4 && k < obs_n; k++) begin
      vectors++;
      if ({obs_last[k], obs_data[k], hs_cyc[k]} !== {(k == 3), bmem[(10 + k) % D], 3 + k}) begin
        miscompares++;
        $display("FAIL basic_word%0d got data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                 k, obs_data[k], obs_last[k], hs_cyc[k], bmem[(10 + k) % D], (k == 3), 3 + k);
      end
    end
    vectors++; if (first_valid !== 3) begin miscompares++; $display("FAIL basic_first_valid got %0d want 3", first_valid); end
    vectors++; if (done_cyc !== 7 || done_cnt !== 1) begin miscompares++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=7 cnt=1", done_cyc, done_cnt); end
    vectors++; if (issued !== 4) begin miscompares++; $display("FAIL basic_issued got %0d want 4", issued); end
  endtask

  task automatic test_wrap();
    bit to;
    run_cmd(14, 5, 0, 0, to);
    vectors++; if (to || obs_n !== 5) begin miscompares++; $display("FAIL wrap_count got %0d timeout=%b want 5", obs_n, to); end
    for (int k = 0; k < 5 && k < addr_n && k < obs_n; k++) begin
      vectors++;
      if ({addr_log[k], obs_data[k], obs_last[k]} !== {AW'((14 + k) % D), bmem[(14 + k) % D], (k == 4)}) begin
        miscompares++;
        $display("FAIL wrap_word%0d got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                 k, addr_log[k], obs_data[k], obs_last[k], (14 + k) % D, bmem[(14 + k) % D], (k == 4));
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    run_cmd(7, 6, 1, 0, to);
    vectors++; if (to || obs_n !== 6) begin miscompares++; $display("FAIL bp_count got %0d timeout=%b want 6", obs_n, to); end
    for (int k = 0; k < 6 && k < obs_n; k++) begin
      vectors++;
      if ({obs_data[k], obs_last[k]} !== {bmem[(7 + k) % D], (k == 5)}) begin
        miscompares++;
        $display("FAIL bp_word%0d got %h/%b want %h/%b", k, obs_data[k], obs_last[k], bmem[(7 + k) % D], (k == 5));
      end
    end
    vectors++; if (stall_err !== 0) begin miscompares++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
    vectors++; if (credit_err !== 0) begin miscompares++; $display("FAIL bp_credit got %0d overruns want 0", credit_err); end
    vectors++; if (!(last_issue > 6) || issued !== 6) begin miscompares++; $display("FAIL bp_en_gap got last_issue=%0d issued=%0d want >6 and 6", last_issue, issued); end
    vectors++; if (obs_n > 0 && done_cyc !== hs_cyc[5] + 1) begin miscompares++; $display("FAIL bp_done got %0d want %0d", done_cyc, hs_cyc[5] + 1); end
  endtask

  task automatic test_len0_and_busy_start();
    bit to;
    run_cmd(3, 0, 0, 0, to);
    vectors++;
    if (to || issued !== 0 || valid_cnt !== 0 || busy_cnt !== 1 || done_cyc !== 1 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL len0 got issued=%0d valid=%0d busy=%0d done_cyc=%0d done=%0d want 0 0 1 1 1",
               issued, valid_cnt, busy_cnt, done_cyc, done_cnt);
    end
    run_cmd(2, 8, 0, 2, to);
    vectors++; if (to || obs_n !== 8 || done_cnt !== 1) begin miscompares++; $display("FAIL busy_start got words=%0d done=%0d want 8 1", obs_n, done_cnt); end
    for (int k = 0; k < 8 && k < obs_n; k++) begin
      vectors++;
      if ({obs_data[k], obs_last[k]} !== {bmem[(2 + k) % D], (k == 7)}) begin
        miscompares++;
        $display("FAIL busy_start_word%0d got %h/%b want %h/%b", k, obs_data[k], obs_last[k], bmem[(2 + k) % D], (k == 7));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd3; len = 5'd8; clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0; m_ready = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (obs_n >= 3) begin to = 1'b0; break; end
    end
    vectors++; if (to) begin miscompares++; $display("FAIL mid_timeout got %0d words want 3", obs_n); end
    rst_n = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; clr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, m_valid, m_last, m_data, mem_en, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_state got busy=%b done=%b valid=%b last=%b data=%h en=%b addr=%h want all 0",
               busy, done, m_valid, m_last, m_data, mem_en, mem_addr);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (valid_cnt !== 0 || done_cnt !== 0 || issued !== 0 || busy_cnt !== 0) begin
      miscompares++;
      $display("FAIL mid_quiet got valid=%0d done=%0d issued=%0d busy=%0d want 0", valid_cnt, done_cnt, issued, busy_cnt);
    end
    $display("reset mid-command");
    run_cmd(0, 2, 0, 0, to);
    vectors++;
    if (to || obs_n !== 2 || {obs_data[0], obs_last[0], obs_data[1], obs_last[1]} !== {bmem[0], 1'b0, bmem[1], 1'b1}) begin
      miscompares++;
      $display("FAIL mid_restart got n=%0d %h/%b %h/%b want 2 %h/0 %h/1",
               obs_n, obs_data[0], obs_last[0], obs_data[1], obs_last[1], bmem[0], bmem[1]);
    end
  endtask

  task automatic test_full_depth();
    bit to;
    run_cmd(5, D, 0, 0, to);
    vectors++; if (to || obs_n !== D || issued !== D) begin miscompares++; $display("FAIL full_count got words=%0d issued=%0d want %0d", obs_n, issued, D); end
    for (int k = 0; k < D && k < obs_n && k < addr_n; k++) begin
      vectors++;
      if ({addr_log[k], obs_data[k], obs_last[k]} !== {AW'((5 + k) % D), bmem[(5 + k) % D], (k == D - 1)}) begin
        miscompares++;
        $display("FAIL full_word%0d got addr=%0d %h/%b want addr=%0d %h/%b",
                 k, addr_log[k], obs_data[k], obs_last[k], (5 + k) % D, bmem[(5 + k) % D], (k == D - 1));
      end
    end
  endtask

  task automatic test_random();
    bit to;
    int b, n;
    for (int i = 0; i < D; i++) bmem[i] = W'($urandom);
    for (int it = 0; it < 8; it++) begin
      b = $urandom_range(D - 1);
      n = $urandom_range(D, 1);
      run_cmd(b, n, 2, 0, to);
      vectors++;
      if (to || obs_n !== n || done_cnt !== 1 || stall_err !== 0 || credit_err !== 0) begin
        miscompares++;
        $display("FAIL rand%0d got words=%0d done=%0d stall=%0d credit=%0d want %0d 1 0 0",
                 it, obs_n, done_cnt, stall_err, credit_err, n);
      end
      for (int k = 0; k < n && k < obs_n; k++) begin
        vectors++;
        if ({obs_data[k], obs_last[k]} !== {bmem[(b + k) % D], (k == n - 1)}) begin
          miscompares++;
          $display("FAIL rand%0d_word%0d got %h/%b want %h/%b", it, k, obs_data[k], obs_last[k], bmem[(b + k) % D], (k == n - 1));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) bmem[i] = W'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_and_busy_start();
    test_reset_mid();
    test_full_depth();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
